// File: rtl/flash_prog_sequencer.sv
// Flash programming sequencer: detects the UART sync sequence, holds the core
// and streams received byte pairs as 16-bit words into flash port A.
module flash_prog_sequencer #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 5000000,
  parameter logic [7:0]  SYNC0   = 8'd169,
  parameter logic [7:0]  SYNC1   = 8'd68,
  parameter logic [7:0]  SYNC2   = 8'd69
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_toggle,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [15:0]       flash_wdata,
  output logic              flash_we,
  output logic              prog_mode,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] word_count
);
  localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    HUNT0, HUNT1, HUNT2, WAIT_HI, WAIT_LO, WRITE, EXIT
  } state_t;

  state_t            state, state_n;
  logic              rx_toggle_p0;
  logic              armed_p0;
  logic              byte_vld;
  logic              in_sess;
  logic              timed_out;
  logic              start, adv, ld_hi, ld_lo;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W-1:0] wr_addr;

  // Byte-event detection: the first cycle after reset only primes the copy
  assign byte_vld = armed_p0 && (rx_toggle != rx_toggle_p0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_toggle_p0 <= 1'b0;
      armed_p0     <= 1'b0;
    end else begin
      rx_toggle_p0 <= rx_toggle;
      armed_p0     <= 1'b1;
    end
  end

  assign in_sess   = (state == WAIT_HI) || (state == WAIT_LO) || (state == WRITE);
  assign timed_out = (to_cnt <= TO_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HUNT0;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    adv       = 1'b0;
    ld_hi     = 1'b0;
    ld_lo     = 1'b0;
    flash_we  = 1'b0;
    prog_mode = 1'b0;
    unique case (state)
      HUNT0: if (byte_vld && rx_data == SYNC0) state_n = HUNT1;
      HUNT1: begin
        if (byte_vld) begin
          if (rx_data == SYNC1)      state_n = HUNT2;
          else if (rx_data == SYNC0) state_n = HUNT1;
          else                       state_n = HUNT0;
        end
      end
      HUNT2: begin
        if (byte_vld) begin
          if (rx_data == SYNC2) begin
            state_n = WAIT_HI;
            start   = 1'b1;
          end else if (rx_data == SYNC0) begin
            state_n = HUNT1;
          end else begin
            state_n = HUNT0;
          end
        end
      end
      WAIT_HI: begin
        prog_mode = 1'b1;
        if (byte_vld) begin
          ld_hi   = 1'b1;
          state_n = WAIT_LO;
        end else if (timed_out) begin
          state_n = EXIT;
        end
      end
      WAIT_LO: begin
        prog_mode = 1'b1;
        if (byte_vld) begin
          ld_lo   = 1'b1;
          state_n = WRITE;
        end else if (timed_out) begin
          state_n = EXIT;
        end
      end
      WRITE: begin
        prog_mode = 1'b1;
        flash_we  = 1'b1;
        adv       = 1'b1;
        // A byte landing during the write cycle starts the next word
        if (byte_vld) begin
          ld_hi   = 1'b1;
          state_n = WAIT_LO;
        end else if (timed_out) begin
          state_n = EXIT;
        end else begin
          state_n = WAIT_HI;
        end
      end
      EXIT: begin
        prog_mode = 1'b1;
        state_n   = HUNT0;
      end
      default: state_n = HUNT0;
    endcase
  end

  assign cpu_hold   = prog_mode;
  assign flash_addr = prog_mode ? wr_addr : cpu_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_addr     <= '0;
      word_count  <= '0;
      flash_wdata <= '0;
      to_cnt      <= '0;
    end else begin
      if (start) begin
        wr_addr    <= '0;
        word_count <= '0;
      end else if (adv) begin
        wr_addr    <= wr_addr + 1'b1;
        word_count <= word_count + 1'b1;
      end
      if (ld_hi) flash_wdata[15:8] <= rx_data;
      if (ld_lo) flash_wdata[7:0]  <= rx_data;
      // Idle timer restarts on session entry and on every in-session byte
      if (start || (in_sess && byte_vld)) to_cnt <= TO_LOAD;
      else if (in_sess && to_cnt != '0)   to_cnt <= to_cnt - 1'b1;
    end
  end
endmodule
